// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the data memory.
// host_lock_in is present only when ARB_HOST_LOCK_EN is defined.
interface data_memory_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
);
    logic                  cpu_req_in;
    logic                  cpu_wr_in;
    logic [ADDR_WIDTH-1:0] cpu_addr_in;
    logic [DATA_WIDTH-1:0] cpu_data_in;
    logic                  cpu_gnt_out;
    logic                  cpu_valid_out;
    logic [DATA_WIDTH-1:0] cpu_data_out;

    logic                  host_req_in;
    logic                  host_wr_in;
    logic [ADDR_WIDTH-1:0] host_addr_in;
    logic [DATA_WIDTH-1:0] host_data_in;
    logic                  host_gnt_out;
    logic                  host_valid_out;
    logic [DATA_WIDTH-1:0] host_data_out;
`ifdef ARB_HOST_LOCK_EN
    logic                  host_lock_in;
`endif

    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_wr_out;
    logic [DATA_WIDTH-1:0] mem_data_in;

    // Requester/memory side: drives requests and read data, observes grants and memory controls.
    modport master (
`ifdef ARB_HOST_LOCK_EN
        output host_lock_in,
`endif
        output cpu_req_in, cpu_wr_in, cpu_addr_in, cpu_data_in,
        input  cpu_gnt_out, cpu_valid_out, cpu_data_out,
        output host_req_in, host_wr_in, host_addr_in, host_data_in,
        input  host_gnt_out, host_valid_out, host_data_out,
        input  mem_addr_out, mem_data_out, mem_wr_out,
        output mem_data_in
    );

    modport slave (
`ifdef ARB_HOST_LOCK_EN
        input  host_lock_in,
`endif
        input  cpu_req_in, cpu_wr_in, cpu_addr_in, cpu_data_in,
        output cpu_gnt_out, cpu_valid_out, cpu_data_out,
        input  host_req_in, host_wr_in, host_addr_in, host_data_in,
        output host_gnt_out, host_valid_out, host_data_out,
        output mem_addr_out, mem_data_out, mem_wr_out,
        input  mem_data_in
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Single-port data memory arbiter: CPU has fixed priority, host is guaranteed access after MAX_WAIT blocked cycles.
// Defining ARB_HOST_LOCK_EN enables host_lock_in and the exclusive HOST_LOCK ownership state.
module data_memory_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_WAIT   = 4
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    data_memory_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_CPU_OWN,
        ST_HOST_OWN,
        ST_HOST_LOCK
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       cpu_valid_q, cpu_valid_d;
    logic       host_valid_q, host_valid_d;
    logic       cpu_gnt;
    logic       host_gnt;
    logic       lock_req;

`ifdef ARB_HOST_LOCK_EN
    assign lock_req = bus.host_lock_in;
`else
    assign lock_req = 1'b0;
`endif

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= ST_RESET;
            wait_cnt_q   <= '0;
            cpu_valid_q  <= 1'b0;
            host_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            cpu_valid_q  <= cpu_valid_d;
            host_valid_q <= host_valid_d;
        end
    end

    // Grants are decided from the registered owner state and this cycle's requests.
    always_comb begin
        state_d  = state_q;
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                state_d = ST_IDLE;
            end
            ST_IDLE, ST_CPU_OWN, ST_HOST_OWN: begin
                if (bus.host_req_in && (!bus.cpu_req_in || (wait_cnt_q == WAIT_LIMIT))) begin
                    host_gnt = 1'b1;
                end else if (bus.cpu_req_in) begin
                    cpu_gnt = 1'b1;
                end
                if (host_gnt) begin
                    if ((state_q == ST_HOST_OWN) && lock_req) begin
                        state_d = ST_HOST_LOCK;
                    end else begin
                        state_d = ST_HOST_OWN;
                    end
                end else if (cpu_gnt) begin
                    state_d = ST_CPU_OWN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOST_LOCK: begin
                host_gnt = bus.host_req_in;
                state_d  = lock_req ? ST_HOST_LOCK : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Host starvation counter; held at zero while the host owns the memory exclusively.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_HOST_LOCK) begin
            wait_cnt_d = '0;
        end else if (!bus.host_req_in || host_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_comb begin
        bus.mem_addr_out = '0;
        bus.mem_data_out = '0;
        bus.mem_wr_out   = 1'b0;
        if (host_gnt) begin
            bus.mem_addr_out = bus.host_addr_in;
            bus.mem_data_out = bus.host_data_in;
            bus.mem_wr_out   = bus.host_wr_in;
        end else if (cpu_gnt) begin
            bus.mem_addr_out = bus.cpu_addr_in;
            bus.mem_data_out = bus.cpu_data_in;
            bus.mem_wr_out   = bus.cpu_wr_in;
        end
    end

    // Memory read data arrives one cycle after the address, so valid trails the read grant by one cycle.
    always_comb begin
        cpu_valid_d  = cpu_gnt & ~bus.cpu_wr_in;
        host_valid_d = host_gnt & ~bus.host_wr_in;
    end

    assign bus.cpu_gnt_out    = cpu_gnt;
    assign bus.host_gnt_out   = host_gnt;
    assign bus.cpu_valid_out  = cpu_valid_q;
    assign bus.host_valid_out = host_valid_q;
    assign bus.cpu_data_out   = cpu_valid_q ? bus.mem_data_in : '0;
    assign bus.host_data_out  = host_valid_q ? bus.mem_data_in : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: directed scenarios followed by random two-requester traffic.
module tb_data_memory_arbiter;
    localparam int DW = 16;
    localparam int AW = 11;
    localparam int MW = 4;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    data_memory_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clock_in(clk),
        .reset_in(rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 40503 + 4660);
    endfunction

    // Environment memory: synchronous read, write at the grant edge.
    logic [DW-1:0] env_mem [int];
    logic [DW-1:0] rdata = '0;
    always @(posedge clk) begin
        rdata <= env_mem.exists(int'(bus.mem_addr_out)) ? env_mem[int'(bus.mem_addr_out)]
                                                       : init_val(int'(bus.mem_addr_out));
        if (bus.mem_wr_out) env_mem[int'(bus.mem_addr_out)] = bus.mem_data_out;
    end
    assign bus.mem_data_in = rdata;

    // Reference model state
    logic [DW-1:0] gold [int];
    logic [DW-1:0] cpu_q[$];
    logic [DW-1:0] host_q[$];
    logic          c_pend, c_wr, h_pend, h_wr, h_lock;
    logic [AW-1:0] c_addr, h_addr;
    logic [DW-1:0] c_data, h_data;
    int            blocked;
    bit            first_cycle;
    bit            locked;
    int            prev_owner;

    function automatic logic [DW-1:0] gold_rd(input logic [AW-1:0] a);
        return gold.exists(int'(a)) ? gold[int'(a)] : init_val(int'(a));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        bus.cpu_req_in   = c_pend;
        bus.cpu_wr_in    = c_wr;
        bus.cpu_addr_in  = c_addr;
        bus.cpu_data_in  = c_data;
        bus.host_req_in  = h_pend;
        bus.host_wr_in   = h_wr;
        bus.host_addr_in = h_addr;
        bus.host_data_in = h_data;
`ifdef ARB_HOST_LOCK_EN
        bus.host_lock_in = h_lock;
`endif
    endtask

    task automatic model_reset();
        first_cycle = 1'b1;
        locked      = 1'b0;
        blocked     = 0;
        prev_owner  = 0;
    endtask

    // One arbitration cycle of the reference model, compared with the DUT's combinational outputs.
    task automatic check_cycle();
        logic          eh, ec, ew, nxt_lock;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (first_cycle) begin
            eh = 1'b0; ec = 1'b0;
        end else if (locked) begin
            eh = h_pend; ec = 1'b0;
        end else begin
            eh = h_pend && (!c_pend || blocked == MW);
            ec = c_pend && !eh;
        end
        ea = eh ? h_addr : (ec ? c_addr : '0);
        ed = eh ? h_data : (ec ? c_data : '0);
        ew = eh ? h_wr : (ec ? c_wr : 1'b0);
        chk("gnt", 64'({bus.cpu_gnt_out, bus.host_gnt_out}), 64'({ec, eh}));
        chk("membus", 64'({bus.mem_wr_out, bus.mem_addr_out, bus.mem_data_out}), 64'({ew, ea, ed}));
        if (eh) begin
            if (h_wr) gold[int'(h_addr)] = h_data; else host_q.push_back(gold_rd(h_addr));
        end
        if (ec) begin
            if (c_wr) gold[int'(c_addr)] = c_data; else cpu_q.push_back(gold_rd(c_addr));
        end
        nxt_lock = locked ? h_lock : (eh && prev_owner == 2 && h_lock);
        if (locked || !h_pend || eh) blocked = 0;
        else if (blocked < MW) blocked++;
        prev_owner  = locked ? 0 : (eh ? 2 : (ec ? 1 : 0));
        locked      = nxt_lock;
        first_cycle = 1'b0;
        if (eh) h_pend = 1'b0;
        if (ec) c_pend = 1'b0;
    endtask

    task automatic drive_check();
        drive();
        #2;
        check_cycle();
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_check();
    endtask

    task automatic cpu_read_rand();
        c_pend = 1'b1; c_wr = 1'b0; c_addr = AW'($urandom_range(0, 15)); c_data = DW'($urandom);
    endtask

    // Monitor: pops the expected read data whenever a requester presents valid.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.cpu_valid_out) begin
                if (cpu_q.size() == 0) chk("cpu_valid_unexpected", 64'(1), 64'(0));
                else chk("cpu_rdata", 64'(bus.cpu_data_out), 64'(cpu_q.pop_front()));
            end
            if (bus.host_valid_out) begin
                if (host_q.size() == 0) chk("host_valid_unexpected", 64'(1), 64'(0));
                else chk("host_rdata", 64'(bus.host_data_out), 64'(host_q.pop_front()));
            end
        end
    end

    initial begin
        int n;
        bit got;
        c_pend = 0; c_wr = 0; c_addr = '0; c_data = '0;
        h_pend = 0; h_wr = 0; h_addr = '0; h_data = '0; h_lock = 0;
        model_reset();
        rst_n = 1'b0;
        c_pend = 1'b1;
        drive();
        repeat (3) @(negedge clk);
        #2;
        chk("reset_ctl", 64'({bus.cpu_gnt_out, bus.host_gnt_out, bus.cpu_valid_out,
                              bus.host_valid_out, bus.mem_wr_out}), 64'(0));
        chk("reset_data", 64'({bus.mem_addr_out, bus.mem_data_out, bus.cpu_data_out}), 64'(0));
        c_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive_check();
        cycle();

        // CPU read in IDLE: same-cycle grant, data next cycle
        c_pend = 1; c_wr = 0; c_addr = 11'h005;
        cycle();
        chk("cpu_gnt_idle", 64'(bus.cpu_gnt_out), 64'(1));

        // Host write with CPU idle, then CPU reads it back
        h_pend = 1; h_wr = 1; h_addr = 11'h010; h_data = 16'h1234;
        cycle();
        chk("host_wr_en", 64'({bus.host_gnt_out, bus.mem_wr_out}), 64'(2'b11));
        c_pend = 1; c_wr = 0; c_addr = 11'h010;
        cycle();
        cycle();

        // Continuous CPU traffic: host granted on cycle MAX_WAIT+1
        cpu_read_rand();
        h_pend = 1; h_wr = 0; h_addr = 11'h00a;
        n = 0; got = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            cycle();
            if (!c_pend) cpu_read_rand();
            if (bus.host_gnt_out) begin got = 1; n = i; end
        end
        chk("host_wait_full", 64'(n), 64'(MW + 1));

        // Host gives up after 2 blocked cycles; the re-request waits the full MAX_WAIT again
        h_pend = 1; h_wr = 1; h_addr = 11'h00b; h_data = 16'hcafe;
        for (int i = 0; i < 2; i++) begin
            cycle();
            if (!c_pend) cpu_read_rand();
        end
        h_pend = 0;
        cycle();
        if (!c_pend) cpu_read_rand();
        h_pend = 1;
        n = 0; got = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            cycle();
            if (!c_pend) cpu_read_rand();
            if (bus.host_gnt_out) begin got = 1; n = i; end
        end
        chk("host_wait_rearm", 64'(n), 64'(MW + 1));
        c_pend = 0;
        cycle();

`ifdef ARB_HOST_LOCK_EN
        // Host takes the lock; the CPU is shut out until the lock is released
        h_pend = 1; h_wr = 1; h_addr = 11'h030; h_data = 16'h0001; h_lock = 1;
        cycle();
        h_pend = 1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            cpu_read_rand();
            h_pend = 1; h_data = DW'($urandom);
            cycle();
            chk("lock_cpu_blocked", 64'(bus.cpu_gnt_out), 64'(0));
        end
        h_lock = 0; h_pend = 0;
        cycle();
        cycle();
        chk("lock_release", 64'(bus.cpu_gnt_out), 64'(1));
        cycle();
`endif

        // Reset asserted in the middle of a CPU write grant: the write is dropped
        c_pend = 1; c_wr = 1; c_addr = 11'h020; c_data = 16'hbeef; h_pend = 0;
        @(negedge clk);
        drive();
        #2;
        chk("wr_before_rst", 64'({bus.cpu_gnt_out, bus.mem_wr_out}), 64'(2'b11));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", 64'({bus.cpu_gnt_out, bus.host_gnt_out, bus.mem_wr_out,
                                  bus.cpu_valid_out, bus.host_valid_out}), 64'(0));
        chk("rst_async_bus", 64'({bus.mem_addr_out, bus.mem_data_out}), 64'(0));
        c_wr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive_check();
        chk("no_gnt_in_reset", 64'(bus.cpu_gnt_out), 64'(0));
        cycle();
        cycle();

        // Random traffic from both requesters over a small address window
        for (int i = 0; i < 400; i++) begin
            if (!c_pend && $urandom_range(0, 99) < 60) begin
                c_pend = 1; c_wr = 1'($urandom); c_addr = AW'($urandom_range(0, 15)); c_data = DW'($urandom);
            end
            if (!h_pend && $urandom_range(0, 99) < 35) begin
                h_pend = 1; h_wr = 1'($urandom); h_addr = AW'($urandom_range(0, 15)); h_data = DW'($urandom);
            end
            cycle();
        end

        c_pend = 0; h_pend = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("scoreboard_drained", 64'(cpu_q.size() + host_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
